// File: rtl/chip8_mem_responder.sv
// chip8_mem_responder: single-initiator request port over program RAM and VRAM, plus a pipelined VRAM scanout port
//   clk_in, rst_in                    : clock, synchronous active-high reset
//   mem_valid_in, mem_we_in,
//   mem_type_in, mem_addr_in,
//   mem_data_in                       : single-beat request (type 0 = RAM, 1 = VRAM)
//   mem_ready_out                     : request can be accepted this cycle
//   mem_valid_out, mem_data_out       : one-cycle read response, data held until the next read completes
//   protocol_err                      : sticky, set by a request presented while not ready
//   scan_x_in, scan_y_in,
//   scan_pixel_out                    : pixel of the (x,y) presented two cycles earlier
module chip8_mem_responder #(
    parameter int RAM_DEPTH     = 4096,
    parameter int VRAM_DEPTH    = 256,
    parameter int READ_LATENCY  = 2,
    parameter     RAM_INIT_FILE = ""
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        mem_valid_in,
    input  logic        mem_we_in,
    input  logic        mem_type_in,
    input  logic [15:0] mem_addr_in,
    input  logic [7:0]  mem_data_in,
    output logic        mem_ready_out,
    output logic        mem_valid_out,
    output logic [7:0]  mem_data_out,
    output logic        protocol_err,
    input  logic [5:0]  scan_x_in,
    input  logic [4:0]  scan_y_in,
    output logic        scan_pixel_out
);
    localparam int AW  = $clog2(RAM_DEPTH);
    localparam int VAW = $clog2(VRAM_DEPTH);
    localparam int LW  = $clog2(READ_LATENCY + 1);

    typedef enum logic {IDLE, READ_WAIT} state_t;

    logic [7:0]    ram [RAM_DEPTH];
    logic [7:0]    vram [VRAM_DEPTH];
    state_t        state_q, state_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic          type_q, type_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          valid_q, valid_d;
    logic [7:0]    data_q, data_d;
    logic          err_q, err_d;
    logic [7:0]    scan_byte_q;
    logic [2:0]    scan_bit_q;
    logic          pixel_q;
    logic          accept, wr, done;
    logic [7:0]    rd_byte;
    logic          unused_ok;

    // The preload image is applied by the implementation flow's memory initialisation, not by this RTL.
    assign unused_ok = ^{mem_addr_in[15:AW], RAM_INIT_FILE != ""};

    assign accept  = mem_valid_in && state_q == IDLE;
    assign wr      = accept && mem_we_in;
    assign done    = state_q == READ_WAIT && cnt_q == '0;
    assign rd_byte = type_q ? vram[addr_q[VAW-1:0]] : ram[addr_q];

    always_comb begin
        state_d = done ? IDLE : state_q;
        cnt_d   = state_q == READ_WAIT && !done ? cnt_q - 1'b1 : cnt_q;
        type_d  = type_q;
        addr_d  = addr_q;
        valid_d = done;
        data_d  = done ? rd_byte : data_q;
        err_d   = err_q || (mem_valid_in && state_q != IDLE);
        if (accept && !mem_we_in) begin
            state_d = READ_WAIT;
            cnt_d   = LW'(READ_LATENCY - 1);
            type_d  = mem_type_in;
            addr_d  = mem_addr_in[AW-1:0];
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            type_q  <= 1'b0;
            addr_q  <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
            pixel_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            type_q  <= type_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            err_q   <= err_d;
            pixel_q <= scan_byte_q[scan_bit_q];
        end
    end

    always_ff @(posedge clk_in) begin
        if (wr && !mem_type_in) ram[mem_addr_in[AW-1:0]] <= mem_data_in;
    end

    // Scanout reads the old byte when the request port writes the same byte in the same cycle.
    always_ff @(posedge clk_in) begin
        if (wr && mem_type_in) vram[mem_addr_in[VAW-1:0]] <= mem_data_in;
        scan_byte_q <= vram[{scan_y_in, scan_x_in[5:3]}];
        scan_bit_q  <= 3'd7 - scan_x_in[2:0];
    end

    assign mem_ready_out  = state_q == IDLE;
    assign mem_valid_out  = valid_q;
    assign mem_data_out   = data_q;
    assign protocol_err   = err_q;
    assign scan_pixel_out = pixel_q;
endmodule

// File: tb/tb_chip8_mem_responder.sv
// tb_chip8_mem_responder: scoreboard bench for chip8_mem_responder request and scanout ports
module tb_chip8_mem_responder;
    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        mem_valid_in = 1'b0;
    logic        mem_we_in = 1'b0;
    logic        mem_type_in = 1'b0;
    logic [15:0] mem_addr_in = '0;
    logic [7:0]  mem_data_in = '0;
    logic        mem_ready_out, mem_valid_out, protocol_err, scan_pixel_out;
    logic [7:0]  mem_data_out;
    logic [5:0]  scan_x_in = '0;
    logic [4:0]  scan_y_in = '0;
    int          total = 0;
    int          bad = 0;
    int          nvalid = 0;
    int          nv;
    logic [7:0]  mram [4096];
    logic [7:0]  mvram [256];
    logic [7:0]  rq [$];
    logic        sq [$];
    logic        scan_chk = 1'b0;
    logic        p1 = 1'b0;
    logic        p2 = 1'b0;

    chip8_mem_responder dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .mem_valid_in(mem_valid_in), .mem_we_in(mem_we_in), .mem_type_in(mem_type_in),
        .mem_addr_in(mem_addr_in), .mem_data_in(mem_data_in),
        .mem_ready_out(mem_ready_out), .mem_valid_out(mem_valid_out), .mem_data_out(mem_data_out),
        .protocol_err(protocol_err),
        .scan_x_in(scan_x_in), .scan_y_in(scan_y_in), .scan_pixel_out(scan_pixel_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk_in) begin
        p1 <= scan_chk;
        p2 <= p1;
    end

    always @(negedge clk_in) begin
        if (mem_valid_out) begin
            nvalid++;
            if (rq.size() == 0) chk("spurious_valid", 32'(mem_valid_out), 32'd0);
            else chk("rd_data", 32'(mem_data_out), 32'(rq.pop_front()));
        end
        if (p2) chk("scan_pixel", 32'(scan_pixel_out), 32'(sq.pop_front()));
    end

    // mode 0: legal request, 1: illegal (presented while busy), 2: legal read whose response is abandoned
    task automatic req(input logic we, input logic typ, input logic [15:0] addr, input logic [7:0] data, input int mode);
        for (int n = 0; mode != 1 && !mem_ready_out && n < 20; n++) @(negedge clk_in);
        if (mode != 1) chk("ready_before_req", 32'(mem_ready_out), 32'd1);
        mem_valid_in = 1'b1;
        mem_we_in    = we;
        mem_type_in  = typ;
        mem_addr_in  = addr;
        mem_data_in  = data;
        if (mode != 1 && we && typ) mvram[addr[7:0]] = data;
        if (mode != 1 && we && !typ) mram[addr[11:0]] = data;
        if (mode == 0 && !we) rq.push_back(typ ? mvram[addr[7:0]] : mram[addr[11:0]]);
        @(negedge clk_in);
        mem_valid_in = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; rq.size() != 0 && n < 20; n++) @(negedge clk_in);
        repeat (2) @(negedge clk_in);
        chk("drain", 32'(rq.size()), 32'd0);
    endtask

    task automatic scan(input logic [5:0] x, input logic [4:0] y);
        logic [7:0] b;
        scan_x_in = x;
        scan_y_in = y;
        scan_chk  = 1'b1;
        b = mvram[{y, x[5:3]}];
        sq.push_back(b[3'd7 - x[2:0]]);
        @(negedge clk_in);
        scan_chk = 1'b0;
    endtask

    task automatic full_frame();
        for (int y = 0; y < 32; y++)
            for (int x = 0; x < 64; x++) scan(6'(x), 5'(y));
        repeat (3) @(negedge clk_in);
        chk("scan_drain", 32'(sq.size()), 32'd0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk_in);
        chk("rst_ready", 32'(mem_ready_out), 32'd1);
        chk("rst_valid", 32'(mem_valid_out), 32'd0);
        chk("rst_data", 32'(mem_data_out), 32'd0);
        chk("rst_err", 32'(protocol_err), 32'd0);
        chk("rst_pixel", 32'(scan_pixel_out), 32'd0);
        rst_in = 1'b0;
        @(negedge clk_in);

        req(1'b1, 1'b0, 16'h0200, 8'hA5, 0);
        req(1'b0, 1'b0, 16'h0200, 8'h00, 0);
        chk("rd_busy1", 32'(mem_ready_out), 32'd0);
        chk("rd_novalid1", 32'(mem_valid_out), 32'd0);
        @(negedge clk_in);
        chk("rd_busy2", 32'(mem_ready_out), 32'd0);
        chk("rd_novalid2", 32'(mem_valid_out), 32'd0);
        @(negedge clk_in);
        chk("rd_valid", 32'(mem_valid_out), 32'd1);
        chk("rd_ready_back", 32'(mem_ready_out), 32'd1);
        @(negedge clk_in);
        chk("rd_pulse", 32'(mem_valid_out), 32'd0);
        chk("rd_hold", 32'(mem_data_out), 32'hA5);
        req(1'b0, 1'b0, 16'h1200, 8'h00, 0);
        drain();

        req(1'b1, 1'b1, 16'h0008, 8'h80, 0);
        req(1'b1, 1'b1, 16'h0009, 8'h00, 0);
        scan(6'd0, 5'd1);
        scan(6'd1, 5'd1);
        scan(6'd8, 5'd1);
        req(1'b0, 1'b1, 16'h0308, 8'h00, 0);
        drain();
        scan_x_in = 6'd0;
        scan_y_in = 5'd1;
        scan_chk  = 1'b1;
        sq.push_back(1'b1);
        mem_valid_in = 1'b1;
        mem_we_in    = 1'b1;
        mem_type_in  = 1'b1;
        mem_addr_in  = 16'h0008;
        mem_data_in  = 8'h00;
        mvram[8]     = 8'h00;
        @(negedge clk_in);
        mem_valid_in = 1'b0;
        scan_chk     = 1'b0;
        scan(6'd0, 5'd1);
        repeat (3) @(negedge clk_in);

        req(1'b1, 1'b1, 16'h0008, 8'h80, 0);
        nv = nvalid;
        req(1'b0, 1'b1, 16'h0008, 8'h00, 0);
        req(1'b0, 1'b1, 16'h0009, 8'h00, 0);
        req(1'b1, 1'b1, 16'h0010, 8'h3C, 0);
        req(1'b1, 1'b1, 16'h0011, 8'hC3, 0);
        drain();
        chk("writes_no_valid", 32'(nvalid - nv), 32'd2);
        req(1'b0, 1'b1, 16'h0010, 8'h00, 0);
        req(1'b0, 1'b1, 16'h0011, 8'h00, 0);
        drain();
        chk("err_clean", 32'(protocol_err), 32'd0);

        req(1'b0, 1'b0, 16'h0200, 8'h00, 0);
        req(1'b1, 1'b0, 16'h0200, 8'h11, 1);
        chk("err_set", 32'(protocol_err), 32'd1);
        drain();
        chk("err_sticky", 32'(protocol_err), 32'd1);
        req(1'b0, 1'b0, 16'h0200, 8'h00, 0);
        drain();
        chk("err_sticky2", 32'(protocol_err), 32'd1);

        nv = nvalid;
        for (int i = 0; i < 256; i++) req(1'b1, 1'b1, 16'(i), 8'($urandom), 0);
        chk("fill_no_valid", 32'(nvalid), 32'(nv));
        full_frame();
        for (int i = 0; i < 256; i++) req(1'b1, 1'b1, 16'(i), 8'h00, 0);
        full_frame();

        req(1'b1, 1'b0, 16'h0345, 8'h5C, 0);
        nv = nvalid;
        req(1'b0, 1'b0, 16'h0345, 8'h00, 2);
        rst_in = 1'b1;
        @(negedge clk_in);
        chk("midrd_ready", 32'(mem_ready_out), 32'd1);
        chk("midrd_valid", 32'(mem_valid_out), 32'd0);
        chk("midrd_err_clr", 32'(protocol_err), 32'd0);
        rst_in = 1'b0;
        repeat (4) @(negedge clk_in);
        chk("midrd_no_resp", 32'(nvalid), 32'(nv));
        chk("midrd_ready2", 32'(mem_ready_out), 32'd1);
        req(1'b0, 1'b0, 16'h0345, 8'h00, 0);
        req(1'b0, 1'b0, 16'h0200, 8'h00, 0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
